// File: rtl/conv_window3x3_if.sv
// Pixel stream in, 3x3 window out, for conv_window3x3.
// The master drives pixels and clr; the slave returns the window with its valid/frame flags.
interface conv_window3x3_if #(parameter int DW = 16);
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [DW-1:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
    logic          out_valid;
    logic          frame_done;

    modport master (
        output clr, in_valid, in_data,
        input  d1, d2, d3, d4, d5, d6, d7, d8, d9, out_valid, frame_done
    );

    modport slave (
        input  clr, in_valid, in_data,
        output d1, d2, d3, d4, d5, d6, d7, d8, d9, out_valid, frame_done
    );
endinterface

// File: rtl/conv_window3x3.sv
// 3x3 sliding window over a raster pixel stream using two line buffers; window valid 1 cycle after its last pixel.
// No backpressure: every in_valid pixel is accepted, and the consumer must take d1..d9 in the out_valid cycle.
module conv_window3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    conv_window3x3_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] win [9];
    logic          out_valid_q;
    logic          frame_done_q;

    logic acc;
    logic col_last;
    logic row_last;
    logic win_done;

    // A clr cycle drops any pixel presented with it.
    assign acc      = bus.in_valid & ~bus.clr;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign win_done = acc && (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.clr) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // lb0 holds row r-1 and lb1 row r-2 at each column; validity is gated by the counters,
    // so these need no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) win[k] <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= win_done;
            frame_done_q <= win_done && row_last && col_last;
            if (acc) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb1[col];
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb0[col];
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= bus.in_data;
            end
        end
    end

    assign bus.d1         = win[0];
    assign bus.d2         = win[1];
    assign bus.d3         = win[2];
    assign bus.d4         = win[3];
    assign bus.d5         = win[4];
    assign bus.d6         = win[5];
    assign bus.d7         = win[6];
    assign bus.d8         = win[7];
    assign bus.d9         = win[8];
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule
